// File: rtl/long_op_scheduler_pkg.sv
// Shared definitions for the long-op scheduler: FSM encoding and the
// mul/div funct3 codes carried to the long unit.
package long_op_scheduler_pkg;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_BUSY    = 2'd1;
   localparam logic [1:0] S_WB_PEND = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = S_IDLE,
      BUSY    = S_BUSY,
      WB_PEND = S_WB_PEND
   } state_t;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

endpackage

// File: rtl/long_op_scheduler_if.sv
// Pipeline-facing bundle of the long-op scheduler: EX issue, ID hazard
// labels, long-unit handshake and the shared regfile write port.
interface long_op_scheduler_if;

   logic        issue_valid_i;
   logic [2:0]  issue_op_i;
   logic [4:0]  issue_rd_i;
   logic [31:0] issue_a_i;
   logic [31:0] issue_b_i;
   logic        flush_i;
   logic        busywait_i;
   logic        issue_ready_o;
   logic        id_is_long_i;
   logic [4:0]  id_rs1_i;
   logic [4:0]  id_rs2_i;
   logic [4:0]  id_rd_i;
   logic        stall_o;
   logic        lu_start_o;
   logic [2:0]  lu_op_o;
   logic [31:0] lu_a_o;
   logic [31:0] lu_b_o;
   logic        lu_done_i;
   logic [31:0] lu_result_i;
   logic        wb_en_i;
   logic [4:0]  wb_rd_i;
   logic [31:0] wb_data_i;
   logic        wb_hold_o;
   logic        rf_we_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_data_o;

   modport slave (
      input  issue_valid_i, issue_op_i, issue_rd_i, issue_a_i, issue_b_i,
      input  flush_i, busywait_i,
      output issue_ready_o,
      input  id_is_long_i, id_rs1_i, id_rs2_i, id_rd_i,
      output stall_o,
      output lu_start_o, lu_op_o, lu_a_o, lu_b_o,
      input  lu_done_i, lu_result_i,
      input  wb_en_i, wb_rd_i, wb_data_i,
      output wb_hold_o, rf_we_o, rf_rd_o, rf_data_o
   );

   modport master (
      output issue_valid_i, issue_op_i, issue_rd_i, issue_a_i, issue_b_i,
      output flush_i, busywait_i,
      input  issue_ready_o,
      output id_is_long_i, id_rs1_i, id_rs2_i, id_rd_i,
      input  stall_o,
      input  lu_start_o, lu_op_o, lu_a_o, lu_b_o,
      output lu_done_i, lu_result_i,
      output wb_en_i, wb_rd_i, wb_data_i,
      input  wb_hold_o, rf_we_o, rf_rd_o, rf_data_o
   );

endinterface

// File: rtl/long_op_scoreboard.sv
// Single-entry scoreboard: remembers the in-flight long op's rd and
// stalls ID on RAW/WAW against it or on a second long op.
module long_op_scoreboard (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       set,
   input  logic [4:0] set_rd,
   input  logic       clear,
   input  logic       id_is_long,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic [4:0] id_rd,
   output logic [4:0] pend_rd,
   output logic       stall
);

   logic pend_valid;
   logic label_hit;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_valid <= 1'b0;
         pend_rd    <= 5'd0;
      end else if (set) begin
         pend_valid <= 1'b1;
         pend_rd    <= set_rd;
      end else if (clear) begin
         pend_valid <= 1'b0;
      end
   end

   assign label_hit = (pend_rd != 5'd0) &&
                      ((pend_rd == id_rs1) || (pend_rd == id_rs2) || (pend_rd == id_rd));

   // Releasing on the write cycle lets the dependent op read through the regfile.
   assign stall = pend_valid && !clear && (label_hit || id_is_long);

endmodule

// File: rtl/long_op_scheduler.sv
// Issues one long op at a time to the external long unit and arbitrates
// the single regfile write port between MEM/WB and the long result.
module long_op_scheduler
   import long_op_scheduler_pkg::*;
#(
   parameter int MAX_DEFER = 4,
   parameter int DEFER_W   = 3
) (
   input logic                clk_i,
   input logic                rst_i,
   long_op_scheduler_if.slave bus
);

   state_t               state;
   logic [31:0]          result_buf;
   logic [DEFER_W-1:0]   defer_cnt;
   logic [4:0]           pend_rd;
   logic                 issue_fire;
   logic                 done_now;
   logic                 defer_max;
   logic                 completing;
   logic                 long_write;
   logic [31:0]          long_data;

   assign issue_fire = bus.issue_valid_i && (state == IDLE) && !bus.flush_i && !bus.busywait_i;
   assign done_now   = (state == BUSY) && bus.lu_done_i;
   assign defer_max  = (state == WB_PEND) && (defer_cnt == DEFER_W'(MAX_DEFER));

   // An x0 result never needs the port, so it retires straight from BUSY.
   assign completing = (done_now && (!bus.wb_en_i || pend_rd == 5'd0)) ||
                       ((state == WB_PEND) && (!bus.wb_en_i || defer_max));
   assign long_write = completing && (pend_rd != 5'd0);
   assign long_data  = (state == BUSY) ? bus.lu_result_i : result_buf;

   assign bus.issue_ready_o = (state == IDLE);
   assign bus.wb_hold_o     = defer_max;

   always_comb begin
      bus.rf_we_o   = bus.wb_en_i && (bus.wb_rd_i != 5'd0);
      bus.rf_rd_o   = bus.wb_rd_i;
      bus.rf_data_o = bus.wb_data_i;
      if (long_write) begin
         bus.rf_we_o   = 1'b1;
         bus.rf_rd_o   = pend_rd;
         bus.rf_data_o = long_data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE;
         result_buf     <= 32'd0;
         defer_cnt      <= '0;
         bus.lu_start_o <= 1'b0;
         bus.lu_op_o    <= 3'd0;
         bus.lu_a_o     <= 32'd0;
         bus.lu_b_o     <= 32'd0;
      end else begin
         bus.lu_start_o <= issue_fire;
         if (issue_fire) begin
            bus.lu_op_o <= bus.issue_op_i;
            bus.lu_a_o  <= bus.issue_a_i;
            bus.lu_b_o  <= bus.issue_b_i;
         end
         case (state)
            IDLE: begin
               if (issue_fire) begin
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (bus.lu_done_i) begin
                  if (completing) begin
                     state <= IDLE;
                  end else begin
                     result_buf <= bus.lu_result_i;
                     defer_cnt  <= '0;
                     state      <= WB_PEND;
                  end
               end
            end
            WB_PEND: begin
               if (completing) begin
                  state <= IDLE;
               end else begin
                  defer_cnt <= defer_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   long_op_scoreboard u_scoreboard (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .set        (issue_fire),
      .set_rd     (bus.issue_rd_i),
      .clear      (completing),
      .id_is_long (bus.id_is_long_i),
      .id_rs1     (bus.id_rs1_i),
      .id_rs2     (bus.id_rs2_i),
      .id_rd      (bus.id_rd_i),
      .pend_rd    (pend_rd),
      .stall      (bus.stall_o)
   );

   // A done pulse outside BUSY means the long unit lost sync with us.
   always @(posedge clk_i) begin
      if (!rst_i && bus.lu_done_i) begin
         assert (state == BUSY) else $error("lu_done_i asserted while scheduler not BUSY");
      end
   end

endmodule

// File: tb/tb_long_op_scheduler.sv
// Directed scenarios followed by random traffic, every cycle compared
// against a transaction-level model of the scheduler.
module tb_long_op_scheduler;
   import long_op_scheduler_pkg::*;

   localparam int MAX_DEFER = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   long_op_scheduler_if bus();

   long_op_scheduler #(.MAX_DEFER(MAX_DEFER), .DEFER_W(3)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int assertCount = 0;
   int failCount   = 0;

   // Model: an op is either waiting on the unit or holding a finished result.
   bit          mWaiting, mHolding, mStart;
   logic [4:0]  mRd;
   logic [31:0] mBuf, mA, mB;
   logic [2:0]  mOp;
   int          mLost;

   bit          eWe, eHold, eStall, eReady, eDone;
   logic [4:0]  eRd;
   logic [31:0] eData;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
      end
   endtask

   task automatic resetModel();
      mWaiting = 0; mHolding = 0; mStart = 0; mRd = 0; mBuf = 0;
      mA = 0; mB = 0; mOp = 0; mLost = 0;
   endtask

   task automatic predict();
      logic [31:0] longData;
      bit          hit;
      longData = 32'd0;
      eDone = 0;
      eHold = 0;
      eWe   = bus.wb_en_i && (bus.wb_rd_i != 5'd0);
      eRd   = bus.wb_rd_i;
      eData = bus.wb_data_i;
      if (mWaiting && bus.lu_done_i && (!bus.wb_en_i || mRd == 5'd0)) begin
         eDone    = 1;
         longData = bus.lu_result_i;
      end
      if (mHolding) begin
         eHold = (mLost == MAX_DEFER);
         if (!bus.wb_en_i || eHold) begin
            eDone    = 1;
            longData = mBuf;
         end
      end
      if (eDone && mRd != 5'd0) begin
         eWe   = 1;
         eRd   = mRd;
         eData = longData;
      end
      hit    = (mRd != 5'd0) && (mRd == bus.id_rs1_i || mRd == bus.id_rs2_i || mRd == bus.id_rd_i);
      eReady = !(mWaiting || mHolding);
      eStall = !eReady && !eDone && (hit || bus.id_is_long_i);
   endtask

   task automatic updateModel();
      bit fire;
      if (rst) begin
         resetModel();
      end else begin
         fire   = bus.issue_valid_i && eReady && !bus.flush_i && !bus.busywait_i;
         mStart = fire;
         if (eDone) begin
            mWaiting = 0;
            mHolding = 0;
         end else if (mWaiting && bus.lu_done_i) begin
            mWaiting = 0;
            mHolding = 1;
            mBuf     = bus.lu_result_i;
            mLost    = 0;
         end else if (mHolding && bus.wb_en_i) begin
            mLost++;
         end
         if (fire) begin
            mWaiting = 1;
            mRd = bus.issue_rd_i;
            mOp = bus.issue_op_i;
            mA  = bus.issue_a_i;
            mB  = bus.issue_b_i;
         end
      end
   endtask

   // One clock: compare at the falling edge, then advance model with the DUT.
   task automatic applyStimulus();
      @(negedge clk);
      predict();
      checkOutput("rf_we", bus.rf_we_o, eWe);
      if (eWe) begin
         checkOutput("rf_rd", bus.rf_rd_o, eRd);
         checkOutput("rf_data", bus.rf_data_o, eData);
      end
      checkOutput("wb_hold", bus.wb_hold_o, eHold);
      checkOutput("stall", bus.stall_o, eStall);
      checkOutput("issue_ready", bus.issue_ready_o, eReady);
      checkOutput("lu_start", bus.lu_start_o, mStart);
      checkOutput("lu_op", bus.lu_op_o, mOp);
      checkOutput("lu_a", bus.lu_a_o, mA);
      checkOutput("lu_b", bus.lu_b_o, mB);
      @(posedge clk);
      updateModel();
      #1;
   endtask

   task automatic clearInputs();
      bus.issue_valid_i = 0; bus.issue_op_i = 0; bus.issue_rd_i = 0;
      bus.issue_a_i = 0; bus.issue_b_i = 0; bus.flush_i = 0; bus.busywait_i = 0;
      bus.id_is_long_i = 0; bus.id_rs1_i = 0; bus.id_rs2_i = 0; bus.id_rd_i = 0;
      bus.lu_done_i = 0; bus.lu_result_i = 0;
      bus.wb_en_i = 0; bus.wb_rd_i = 0; bus.wb_data_i = 0;
   endtask

   task automatic issueOp(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
      bus.issue_valid_i = 1; bus.issue_op_i = op; bus.issue_rd_i = rd;
      bus.issue_a_i = a; bus.issue_b_i = b;
      applyStimulus();
      bus.issue_valid_i = 0;
   endtask

   task automatic finishOp(input logic [31:0] result);
      bus.lu_done_i = 1; bus.lu_result_i = result;
      applyStimulus();
      bus.lu_done_i = 0;
   endtask

   initial begin
      clearInputs();
      rst = 1;
      repeat (2) @(posedge clk);
      resetModel();
      #1;
      rst = 0;
      applyStimulus();

      // Basic op with a RAW reader on rs2.
      issueOp(OP_MUL, 5'd5, 32'd3, 32'd7);
      bus.id_rs2_i = 5'd5;
      repeat (3) applyStimulus();
      finishOp(32'd21);
      applyStimulus();

      // Unrelated ID labels must not stall.
      issueOp(OP_MULHU, 5'd5, 32'h1234, 32'h10);
      bus.id_rs1_i = 5'd6; bus.id_rs2_i = 5'd7; bus.id_rd_i = 5'd8;
      repeat (2) applyStimulus();
      finishOp(32'h12340);
      clearInputs();

      // Port conflict: MEM/WB keeps the port until the hold kicks in.
      issueOp(OP_DIV, 5'd9, 32'd100, 32'd5);
      applyStimulus();
      bus.wb_en_i = 1; bus.wb_rd_i = 5'd3; bus.wb_data_i = 32'h3333;
      finishOp(32'hDEAD);
      repeat (5) applyStimulus();
      clearInputs();
      repeat (2) applyStimulus();

      // Blocked issues, then a second long op arriving while busy.
      bus.issue_valid_i = 1; bus.flush_i = 1; applyStimulus();
      bus.flush_i = 0; bus.busywait_i = 1; applyStimulus();
      bus.busywait_i = 0;
      issueOp(OP_REM, 5'd12, 32'd17, 32'd5);
      bus.issue_valid_i = 1; bus.issue_rd_i = 5'd13; bus.id_is_long_i = 1;
      repeat (2) applyStimulus();
      bus.issue_valid_i = 0;
      finishOp(32'd2);
      clearInputs();
      applyStimulus();

      // x0 destination retires silently, with and without a port conflict.
      issueOp(OP_MUL, 5'd0, 32'd9, 32'd9);
      applyStimulus();
      finishOp(32'd81);
      issueOp(OP_MULH, 5'd0, 32'd2, 32'd2);
      bus.wb_en_i = 1; bus.wb_rd_i = 5'd4; bus.wb_data_i = 32'h44;
      finishOp(32'd4);
      clearInputs();
      applyStimulus();

      // Reset while a result is buffered.
      issueOp(OP_DIVU, 5'd4, 32'd40, 32'd8);
      bus.wb_en_i = 1; bus.wb_rd_i = 5'd2; bus.wb_data_i = 32'h22;
      finishOp(32'd5);
      applyStimulus();
      rst = 1; applyStimulus(); rst = 0;
      clearInputs();
      repeat (3) applyStimulus();

      // Random traffic; done pulses are only offered while an op awaits the unit.
      for (int i = 0; i < 3000; i++) begin
         bus.issue_valid_i = ($urandom_range(0, 1) == 1);
         bus.issue_op_i    = 3'($urandom_range(0, 7));
         bus.issue_rd_i    = 5'($urandom_range(0, 7));
         bus.issue_a_i     = $urandom;
         bus.issue_b_i     = $urandom;
         bus.flush_i       = ($urandom_range(0, 9) == 0);
         bus.busywait_i    = ($urandom_range(0, 6) == 0);
         bus.id_is_long_i  = ($urandom_range(0, 4) == 0);
         bus.id_rs1_i      = 5'($urandom_range(0, 7));
         bus.id_rs2_i      = 5'($urandom_range(0, 7));
         bus.id_rd_i       = 5'($urandom_range(0, 7));
         bus.lu_done_i     = mWaiting && ($urandom_range(0, 2) == 0);
         bus.lu_result_i   = $urandom;
         bus.wb_en_i       = ($urandom_range(0, 9) < 7);
         bus.wb_rd_i       = 5'($urandom_range(0, 7));
         bus.wb_data_i     = $urandom;
         rst               = ($urandom_range(0, 99) == 0);
         applyStimulus();
      end
      rst = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
